button_event: RTL

- Sits directly downstream of the switch debouncer.
- Converts a debounced, clock-synchronous button level into single-cycle event pulses: press, release, long-press, and optional auto-repeat.
- The combined o_Step output drives the CPU single-step and clock-enable logic in riscvsingle.
- No synchronizer is needed: the input is already in the i_Clk domain and bounce-free.

---
 rtl/button_event.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/button_event.sv
// ============================================================================
// Module   : button_event
// Purpose  : Turns a debounced, clock-synchronous button level into
//            single-cycle event pulses (press, release, long-press and,
//            optionally, auto-repeat). o_Step drives the single-step /
//            clock-enable logic of the CPU.
// Optional : `define BUTTON_AUTO_REPEAT_EN enables auto-repeat pulses while
//            the button is held past the long-press time.
// Ports    : i_Clk      system clock
//            i_Reset    synchronous active-high reset
//            i_Switch   debounced button level (already in i_Clk domain)
//            o_Press    1-cycle pulse on press
//            o_Release  1-cycle pulse on release after a reported press
//            o_Long     1-cycle pulse when the hold reaches c_LONG_PRESS
//            o_Held     level, high while in the HELD state
//            o_Repeat   1-cycle auto-repeat pulse (0 without the macro)
//            o_Step     o_Press OR o_Repeat
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module button_event #(
  parameter bit          c_ACTIVE_LOW    = 1'b1,
  parameter int unsigned c_LONG_PRESS    = 12500000,
  parameter int unsigned c_REPEAT_PERIOD = 2500000
) (
  input  logic i_Clk,
  input  logic i_Reset,
  input  logic i_Switch,
  output logic o_Press,
  output logic o_Release,
  output logic o_Long,
  output logic o_Held,
  output logic o_Repeat,
  output logic o_Step
);

  localparam int unsigned c_CNT_W     = 27;
  localparam logic [c_CNT_W-1:0] c_LONG_LIM = c_CNT_W'(c_LONG_PRESS - 1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    PRESSED  = 2'd1,
    HELD     = 2'd2,
    WAIT_REL = 2'd3
  } state_t;

  state_t               state_q, state_d;
  logic [c_CNT_W-1:0]   count_q, count_d;
  logic                 press_q, press_d;
  logic                 release_q, release_d;
  logic                 long_q, long_d;
  logic                 held_q, held_d;
  logic                 repeat_q, repeat_d;
  logic                 step_q, step_d;

  // Button asserted, independent of the board's polarity.
  logic w_pressed;
  assign w_pressed = i_Switch ^ c_ACTIVE_LOW;

`ifdef BUTTON_AUTO_REPEAT_EN
  localparam logic [c_CNT_W-1:0] c_REPEAT_LIM = c_CNT_W'(c_REPEAT_PERIOD - 1);
`else
  // Repeat period is meaningless in this build; consume it so it is not
  // reported as dangling.
  logic w_unused_repeat;
  assign w_unused_repeat = ^c_REPEAT_PERIOD;
`endif

  // --------------------------------------------------------------------------
  // Next-state and next-output logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    long_d    = 1'b0;
    repeat_d  = 1'b0;

    unique case (state_q)
      // A button held through reset must be let go before it can count.
      WAIT_REL: begin
        if (!w_pressed) begin
          state_d = IDLE;
        end
      end

      IDLE: begin
        if (w_pressed) begin
          state_d = PRESSED;
          count_d = '0;
          press_d = 1'b1;
        end
      end

      // Release is checked before the limit so that a release landing on
      // the terminal count wins over the long-press event.
      PRESSED: begin
        if (!w_pressed) begin
          state_d   = IDLE;
          count_d   = '0;
          release_d = 1'b1;
        end else if (count_q == c_LONG_LIM) begin
          state_d = HELD;
          count_d = '0;
          long_d  = 1'b1;
        end else begin
          count_d = count_q + 1'b1;
        end
      end

      HELD: begin
        if (!w_pressed) begin
          state_d   = IDLE;
          count_d   = '0;
          release_d = 1'b1;
        end else begin
`ifdef BUTTON_AUTO_REPEAT_EN
          if (count_q == c_REPEAT_LIM) begin
            count_d  = '0;
            repeat_d = 1'b1;
          end else begin
            count_d = count_q + 1'b1;
          end
`else
          count_d = '0;
`endif
        end
      end

      default: begin
        state_d = WAIT_REL;
        count_d = '0;
      end
    endcase
  end

  // Outputs are registered, so derive them from the next state / next pulses.
  assign held_d = (state_d == HELD);
  assign step_d = press_d | repeat_d;

  // --------------------------------------------------------------------------
  // State and output registers
  // --------------------------------------------------------------------------
  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      state_q   <= WAIT_REL;
      count_q   <= '0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      long_q    <= 1'b0;
      held_q    <= 1'b0;
      repeat_q  <= 1'b0;
      step_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      press_q   <= press_d;
      release_q <= release_d;
      long_q    <= long_d;
      held_q    <= held_d;
      repeat_q  <= repeat_d;
      step_q    <= step_d;
    end
  end

  assign o_Press   = press_q;
  assign o_Release = release_q;
  assign o_Long    = long_q;
  assign o_Held    = held_q;
  assign o_Repeat  = repeat_q;
  assign o_Step    = step_q;

endmodule

`default_nettype wire
